mult_booth: RTL

MULT_BOOTH -- requirements
Module: mult_booth

---
 rtl/mult_booth.sv | 128 ++++++++++++
 1 files changed

// File: rtl/mult_booth.sv
// mult_booth: sequential radix-2 Booth multiplier, 32x32 -> 64-bit product.
// A multiply runs for N iterations, one Booth step per clock in RUN.
// The default build is signed only (N = 32). Define MULT_BOOTH_UNSIGNED_EN to add
// the unsgn input. In that build both operands are widened to 33 bits, N = 33, and
// the core produces MULTU (unsgn=1) or MULT (unsgn=0) results.
// The accumulator is one bit wider than the operand, so subtracting the most
// negative multiplicand cannot overflow.
module mult_booth (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
`ifdef MULT_BOOTH_UNSIGNED_EN
  input  logic        unsgn,
`endif
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] high,
  output logic [31:0] low,
  output logic        busy,
  output logic        done
);

`ifdef MULT_BOOTH_UNSIGNED_EN
  localparam int MW = 33;   // operand width after sign/zero extension
`else
  localparam int MW = 32;
`endif
  localparam int AW = MW + 1;   // accumulator width, one guard bit over the operand
  localparam int N  = MW;       // one Booth step per operand bit
  localparam logic [5:0] LAST = 6'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state;
  logic [AW-1:0]  acc;
  logic [AW-1:0]  m;
  logic [MW-1:0]  q;
  logic           qm1;
  logic [5:0]     cnt;

  logic [AW-1:0]  m_load;
  logic [MW-1:0]  q_load;
  logic [AW-1:0]  sum;
  logic [AW-1:0]  acc_next;
  logic [MW-1:0]  q_next;
  logic           qm1_next;
  logic [63:0]    prod;

`ifdef MULT_BOOTH_UNSIGNED_EN
  // The extension bit is zero for unsigned operands and the sign bit otherwise.
  logic a_ext;
  logic b_ext;
  assign a_ext  = ~unsgn & A[31];
  assign b_ext  = ~unsgn & B[31];
  assign m_load = {a_ext, a_ext, A};
  assign q_load = {b_ext, B};
`else
  assign m_load = {A[31], A};
  assign q_load = B;
`endif

  // Perform one Booth step: conditional add/subtract, then an arithmetic shift of {acc, q, qm1}.
  always_comb begin
    sum = acc;
    case ({q[0], qm1})
      2'b01:   sum = acc + m;
      2'b10:   sum = acc - m;
      default: sum = acc;
    endcase
    acc_next = {sum[AW-1], sum[AW-1:1]};
    q_next   = {sum[0], q[MW-1:1]};
    qm1_next = q[0];
  end

  // The low 64 bits of {acc, q} after the last step form the product.
  assign prod = {acc_next[63-MW:0], q_next};

  // FSM and datapath. Results are registered only on the edge that enters DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      m     <= '0;
      q     <= '0;
      qm1   <= 1'b0;
      cnt   <= '0;
      high  <= '0;
      low   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            m     <= m_load;
            acc   <= '0;
            q     <= q_load;
            qm1   <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          acc <= acc_next;
          q   <= q_next;
          qm1 <= qm1_next;
          cnt <= cnt + 6'd1;
          if (cnt == LAST) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            high  <= prod[63:32];
            low   <= prod[31:0];
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
